// File: rtl/ir_freq_classifier.sv
// N-channel IR beacon edge counter and band classifier with windowed stability filtering.
// Optional input deglitcher is enabled by defining IR_FREQ_GLITCH_FILTER_EN.
module ir_freq_classifier #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 12,
  parameter int GATE_CYCLES    = 10_000_000,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_WINDOWS = 2,
  parameter int BAND0_MIN      = 90,
  parameter int BAND0_MAX      = 110,
  parameter int BAND1_MIN      = 900,
  parameter int BAND1_MAX      = 1100,
  parameter int GLITCH_CYCLES  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        ir,
  output logic [N_CH*CNT_W-1:0]  count,
  output logic                   count_valid,
  output logic [N_CH*2-1:0]      code,
  output logic                   code_valid,
  output logic [N_CH-1:0]        code_change
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int STAB_W = $clog2(STABLE_WINDOWS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              term;
  logic              count_valid_q, code_valid_q;

  always_comb begin
    term   = (gate_q == GATE_LAST);
    gate_d = term ? '0 : gate_q + GATE_W'(1);
  end

  // Stage 1 fires the cycle after the terminal gate count, stage 2 one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gate_q        <= '0;
      count_valid_q <= 1'b0;
      code_valid_q  <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      count_valid_q <= term;
      code_valid_q  <= count_valid_q;
    end
  end

  assign count_valid = count_valid_q;
  assign code_valid  = code_valid_q;

`ifndef IR_FREQ_GLITCH_FILTER_EN
  logic unused_glitch_cfg;
  assign unused_glitch_cfg = (GLITCH_CYCLES > 0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   level;
      logic                   prev_q;
      logic                   edge_det;
      logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
      logic [CNT_W-1:0]       cnt_lat_q;
      logic [31:0]            cnt_ext;
      logic [1:0]             cand, prev_cand_q, code_q;
      logic [STAB_W-1:0]      stab_q, stab_d;
      logic                   commit;
      logic                   chg_q;

      always_ff @(posedge clk) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], ir[gi]};
      end

`ifdef IR_FREQ_GLITCH_FILTER_EN
      localparam int GW = $clog2(GLITCH_CYCLES + 1);
      logic          filt_q;
      logic [GW-1:0] gcnt_q;

      // Filtered level follows the synced input only after GLITCH_CYCLES disagreeing cycles in a row.
      always_ff @(posedge clk) begin
        if (!reset) begin
          filt_q <= 1'b0;
          gcnt_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
          if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
            filt_q <= ~filt_q;
            gcnt_q <= '0;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end else begin
          gcnt_q <= '0;
        end
      end
      assign level = filt_q;
`else
      assign level = sync_q[SYNC_STAGES-1];
`endif

      always_comb begin
        edge_det   = level & ~prev_q;
        edge_cnt_d = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        cnt_ext    = 32'(cnt_lat_q);
        if (cnt_lat_q == CNT_MAX)
          cand = 2'd3;
        else if (cnt_ext >= $unsigned(BAND0_MIN) && cnt_ext <= $unsigned(BAND0_MAX))
          cand = 2'd1;
        else if (cnt_ext >= $unsigned(BAND1_MIN) && cnt_ext <= $unsigned(BAND1_MAX))
          cand = 2'd2;
        else if (cnt_lat_q == '0)
          cand = 2'd0;
        else
          cand = 2'd3;
        if (cand == prev_cand_q)
          stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_W'(1);
        else
          stab_d = STAB_W'(1);
        commit = (stab_d == STAB_MAX) && (cand != code_q);
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          prev_q      <= 1'b0;
          edge_cnt_q  <= '0;
          cnt_lat_q   <= '0;
          prev_cand_q <= 2'd0;
          stab_q      <= '0;
          code_q      <= 2'd0;
          chg_q       <= 1'b0;
        end else begin
          prev_q <= level;
          // An edge seen in the terminal cycle still belongs to the closing window.
          if (term) begin
            cnt_lat_q  <= edge_cnt_d;
            edge_cnt_q <= '0;
          end else begin
            edge_cnt_q <= edge_cnt_d;
          end
          chg_q <= 1'b0;
          if (count_valid_q) begin
            prev_cand_q <= cand;
            stab_q      <= stab_d;
            chg_q       <= commit;
            if (commit) code_q <= cand;
          end
        end
      end

      assign count[gi*CNT_W +: CNT_W] = cnt_lat_q;
      assign code[gi*2 +: 2]          = code_q;
      assign code_change[gi]          = chg_q;
    end
  endgenerate

endmodule

// File: tb/tb_ir_freq_classifier.sv
// Scoreboard bench for ir_freq_classifier: per-window pulse plans with hand-computed counts and codes.
// Works with IR_FREQ_GLITCH_FILTER_EN defined or not; filtered-build expectations are selected below.
module tb_ir_freq_classifier;

  localparam int GATE  = 1000;
  localparam int NROWS = 15;
  localparam int INTR  = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ir = 2'b00;
  logic [15:0] count;
  logic        count_valid;
  logic [3:0]  code;
  logic        code_valid;
  logic [1:0]  code_change;

  ir_freq_classifier #(
    .N_CH(2), .CNT_W(8), .GATE_CYCLES(GATE), .SYNC_STAGES(2), .STABLE_WINDOWS(2),
    .BAND0_MIN(10), .BAND0_MAX(20), .BAND1_MIN(40), .BAND1_MAX(60), .GLITCH_CYCLES(3)
  ) dut (
    .clk(clk), .reset(rst_n), .ir(ir), .count(count), .count_valid(count_valid),
    .code(code), .code_valid(code_valid), .code_change(code_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n0, p0, h0, n1, p1, h1;
    int c0, c1, k0, k1, chg;
  } row_t;

  row_t        plan [NROWS];
  logic [15:0] exp_count_q [$];
  logic [5:0]  exp_code_q [$];
  int          checks = 0;
  int          errors = 0;
  int          row = 0;
  int          wpos = 0;
  bit          toggle = 1'b1;
  logic [15:0] e_cnt;
  logic [5:0]  e_code;

  task automatic set_row(input int i, input int n0, input int p0, input int h0,
                         input int n1, input int p1, input int h1,
                         input int c0, input int c1, input int k0, input int k1, input int chg);
    plan[i].n0 = n0; plan[i].p0 = p0; plan[i].h0 = h0;
    plan[i].n1 = n1; plan[i].p1 = p1; plan[i].h1 = h1;
    plan[i].c0 = c0; plan[i].c1 = c1; plan[i].k0 = k0; plan[i].k1 = k1; plan[i].chg = chg;
  endtask

  function automatic logic pulse(input int pos, input int n, input int p, input int h);
    if (n == 0 || pos < 10) return 1'b0;
    return ((pos - 10) / p < n) && ((pos - 10) % p < h);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Stimulus driver: tracks window position and pushes expectations when a window closes.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        wpos = 0;
        if (row == INTR) row = INTR + 1;
      end else if (wpos == GATE - 1) begin
        if (row < NROWS && row != INTR) begin
          exp_count_q.push_back({8'(plan[row].c1), 8'(plan[row].c0)});
          exp_code_q.push_back({2'(plan[row].chg), 2'(plan[row].k1), 2'(plan[row].k0)});
        end
        row++;
        wpos = 0;
      end else begin
        wpos++;
      end
      @(negedge clk);
      if (toggle) ir = 2'($urandom);
      else if (row < NROWS)
        ir = {pulse(wpos, plan[row].n1, plan[row].p1, plan[row].h1),
              pulse(wpos, plan[row].n0, plan[row].p0, plan[row].h0)};
      else ir = 2'b00;
    end
  end

  // Monitor: pops and compares on every output pulse.
  always @(negedge clk) begin
    if (count_valid === 1'b1) begin
      if (exp_count_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL count_unexpected: got count=%h with no expectation", count);
      end else begin
        e_cnt = exp_count_q.pop_front();
        $display("count_valid t=%0t count0=%0d count1=%0d exp0=%0d exp1=%0d",
                 $time, count[7:0], count[15:8], e_cnt[7:0], e_cnt[15:8]);
        check("count", 32'(count), 32'(e_cnt));
      end
    end
    if (code_valid === 1'b1) begin
      if (exp_code_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL code_unexpected: got code=%h change=%b with no expectation", code, code_change);
      end else begin
        e_code = exp_code_q.pop_front();
        $display("code_valid t=%0t code0=%0d code1=%0d change=%b exp=%0d/%0d/%b",
                 $time, code[1:0], code[3:2], code_change, e_code[1:0], e_code[3:2], e_code[5:4]);
        check("code_and_change", 32'({code_change, code}), 32'(e_code));
      end
    end
  end

  // Cycle index of the first count_valid, counting the release cycle as cycle 1.
  task automatic measure_latency(input string name);
    int n;
    n = 1;
    rst_n = 1'b1;
    while (n < 1200) begin
      @(posedge clk);
      n++;
      #1;
      if (count_valid === 1'b1) break;
    end
    check(name, 32'(n), 32'd1001);
  endtask

  task automatic check_cleared(input string name);
    check(name, 32'({count, code, count_valid, code_valid, code_change}), 32'd0);
  endtask

  initial begin
    int guard;
    set_row(0,    0,  1, 0,  50, 20, 5,    0, 50,  0, 0, 0);
    set_row(1,    0,  1, 0,  50, 20, 5,    0, 50,  0, 2, 2);
    set_row(2,   15, 66, 5,  50, 20, 5,   15, 50,  0, 2, 0);
    set_row(3,   15, 66, 5,  50, 20, 5,   15, 50,  1, 2, 1);
`ifdef IR_FREQ_GLITCH_FILTER_EN
    // 1-cycle pulses never survive the filter, so these windows see no ch0 edges.
    set_row(4,  490,  2, 1,   0,  1, 0,    0,  0,  1, 2, 0);
    set_row(5,  490,  2, 1,   0,  1, 0,    0,  0,  0, 0, 3);
    set_row(6,   15, 66, 5,  10, 66, 5,   15, 10,  0, 0, 0);
    set_row(7,   50, 20, 5,  10, 66, 5,   50, 10,  0, 1, 2);
    set_row(8,   15, 66, 5,  61, 16, 5,   15, 61,  0, 1, 0);
    set_row(9,   50, 20, 5,  61, 16, 5,   50, 61,  0, 3, 2);
    set_row(10,  20, 50, 1,   9, 66, 5,    0,  9,  0, 3, 0);
    set_row(11,  20, 50, 1,   9, 66, 5,    0,  9,  0, 3, 0);
`else
    set_row(4,  490,  2, 1,   0,  1, 0,  255,  0,  1, 2, 0);
    set_row(5,  490,  2, 1,   0,  1, 0,  255,  0,  3, 0, 3);
    set_row(6,   15, 66, 5,  10, 66, 5,   15, 10,  3, 0, 0);
    set_row(7,   50, 20, 5,  10, 66, 5,   50, 10,  3, 1, 2);
    set_row(8,   15, 66, 5,  61, 16, 5,   15, 61,  3, 1, 0);
    set_row(9,   50, 20, 5,  61, 16, 5,   50, 61,  3, 3, 2);
    set_row(10,  20, 50, 1,   9, 66, 5,   20,  9,  3, 3, 0);
    set_row(11,  20, 50, 1,   9, 66, 5,   20,  9,  1, 3, 1);
`endif
    set_row(12,  15, 66, 5,   0,  1, 0,    0,  0,  0, 0, 0);
    set_row(13,  15, 66, 5,  40, 20, 5,   15, 40,  0, 0, 0);
    set_row(14,  15, 66, 5,  40, 20, 5,   15, 40,  1, 2, 3);

    // Reset held with toggling inputs; inputs parked low before release.
    repeat (10) @(negedge clk);
    check_cleared("reset_outputs_a");
    repeat (8) @(negedge clk);
    toggle = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset_outputs_b");
    measure_latency("first_count_valid_cycle");

    // Reset pulse in the middle of the interrupted window.
    guard = 0;
    while (!(row == INTR && wpos == 500) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++; errors++;
      $display("FAIL reach_mid_window: timed out, row=%0d wpos=%0d required row=%0d wpos=500", row, wpos, INTR);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("mid_window_reset_outputs");
    measure_latency("post_reset_count_valid_cycle");

    guard = 0;
    while (row < NROWS && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL finish_windows: timed out at row=%0d required row=%0d", row, NROWS);
    end
    repeat (4) @(negedge clk);
    check("pending_count_expectations", 32'(exp_count_q.size()), 32'd0);
    check("pending_code_expectations", 32'(exp_code_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
